// File: rtl/bcd_decoder.sv
// bcd_decoder: sequential packed-BCD to binary converter (reverse double-dabble).
// Each cycle in SHIFT moves {bcd, bin} right one bit and then subtracts 3 from every
// shifted BCD digit that is >= 8. After SHIFTS iterations, bin holds the binary value.
//
// Optional feature: define BCD_DEC_CHECK_EN to reject inputs containing a digit > 9.
// A rejected input goes straight to DONE with error=1 and a zero result.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   start          conversion request, accepted only in IDLE or DONE
//   bcd_input      packed digits, digit 0 in [3:0]
//   binary_output  low OUT_WIDTH bits of the result, updated on entry to DONE
//   overflow       result does not fit in OUT_WIDTH bits
//   busy           conversion in progress
//   done           result valid; held until the next accepted start
//   error          invalid digit seen (tied to 0 unless BCD_DEC_CHECK_EN)
module bcd_decoder #(
  parameter int unsigned DIGITS    = 10,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned SHIFTS    = 34
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_input,
  output logic [OUT_WIDTH-1:0]  binary_output,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned WorkW = BcdW + SHIFTS;
  localparam int unsigned CntW  = $clog2(SHIFTS + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t            state;
  logic [BcdW-1:0]   bcd;
  logic [SHIFTS-1:0] bin;
  logic [CntW-1:0]   cnt;

  logic [WorkW-1:0]  work_sh;
  logic [BcdW-1:0]   bcd_fix;
  logic [SHIFTS-1:0] bin_sh;
  logic              result_ovf;

  // One iteration: shift right with 0 in, then correct every digit of the shifted value.
  always_comb begin
    work_sh = {bcd, bin} >> 1;
    bcd_fix = work_sh[WorkW-1:SHIFTS];
    bin_sh  = work_sh[SHIFTS-1:0];
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_sh[SHIFTS+4*i +: 4] >= 4'd8) begin
        bcd_fix[4*i +: 4] = work_sh[SHIFTS+4*i +: 4] - 4'd3;
      end
    end
    // Any set bit above the output width means the value does not fit.
    result_ovf = (bin_sh >> OUT_WIDTH) != '0;
  end

`ifdef BCD_DEC_CHECK_EN
  logic digit_bad;

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_input[4*i +: 4] > 4'd9) begin
        digit_bad = 1'b1;
      end
    end
  end
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= StIdle;
      bcd           <= '0;
      bin           <= '0;
      cnt           <= '0;
      binary_output <= '0;
      overflow      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef BCD_DEC_CHECK_EN
      error         <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
`ifdef BCD_DEC_CHECK_EN
            if (digit_bad) begin
              // Rejected input: report immediately, no shifting.
              state         <= StDone;
              binary_output <= '0;
              overflow      <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              error         <= 1'b1;
            end else begin
              error         <= 1'b0;
`endif
              state <= StShift;
              bcd   <= bcd_input;
              bin   <= '0;
              cnt   <= CntW'(SHIFTS);
              busy  <= 1'b1;
              done  <= 1'b0;
`ifdef BCD_DEC_CHECK_EN
            end
`endif
          end
        end
        StShift: begin
          bcd <= bcd_fix;
          bin <= bin_sh;
          cnt <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            // Last iteration: publish the freshly shifted value.
            binary_output <= OUT_WIDTH'(bin_sh);
            overflow      <= result_ovf;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_decoder.sv
// Directed bench for bcd_decoder: hand-computed vectors, latency, back-to-back,
// ignored start, mid-conversion reset and (with BCD_DEC_CHECK_EN) digit rejection.
module tb_bcd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [39:0] bcd_input;
  logic [31:0] binary_output;
  logic        overflow;
  logic        busy;
  logic        done;
  logic        error;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_last = 32'h0;

  always #5 clk = ~clk;

  bcd_decoder #(
    .DIGITS   (10),
    .OUT_WIDTH(32),
    .SHIFTS   (34)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bcd_input    (bcd_input),
    .binary_output(binary_output),
    .overflow     (overflow),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion and follow it to done. glitch > 0 re-pulses start (with a
  // different input) at that many edges after acceptance.
  task automatic run_conv(input string tag, input logic [39:0] bcd, input logic [31:0] exp_bin,
                          input logic exp_ovf, input int glitch);
    int   lat;
    logic both;
    logic unstable;
    logic seen;
    bcd_input = bcd;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, " accept"}, {62'd0, busy, done}, 64'h2);
    lat      = 0;
    both     = 1'b0;
    unstable = 1'b0;
    seen     = 1'b0;
    while (lat < 100 && !seen) begin
      if (glitch > 0 && lat == glitch) begin
        start     = 1'b1;
        bcd_input = 40'h0000000007;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (busy && done) both = 1'b1;
      if (busy && binary_output !== exp_last) unstable = 1'b1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check_eq({tag, " latency"}, 64'(lat), 64'd34);
    check_eq({tag, " excl"}, {63'd0, both}, 64'd0);
    check_eq({tag, " stable"}, {63'd0, unstable}, 64'd0);
    check_eq({tag, " result"}, {32'd0, binary_output}, {32'd0, exp_bin});
    check_eq({tag, " ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
    check_eq({tag, " err"}, {63'd0, error}, 64'd0);
    exp_last = exp_bin;
  endtask

  initial begin
    int done_seen;
    reset     = 1'b1;
    start     = 1'b0;
    bcd_input = 40'h0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst bin", {32'd0, binary_output}, 64'd0);
    check_eq("rst ovf", {63'd0, overflow}, 64'd0);
    check_eq("rst busy", {63'd0, busy}, 64'd0);
    check_eq("rst done", {63'd0, done}, 64'd0);
    check_eq("rst err", {63'd0, error}, 64'd0);
    tick();

    run_conv("zero", 40'h0000000000, 32'h00000000, 1'b0, 0);
    run_conv("1234567890", 40'h1234567890, 32'h499602D2, 1'b0, 0);
    run_conv("4294967295", 40'h4294967295, 32'hFFFFFFFF, 1'b0, 0);
    // Straight from DONE with no idle cycle.
    check_eq("b2b in done", {63'd0, done}, 64'd1);
    run_conv("9999999999", 40'h9999999999, 32'h540BE3FF, 1'b1, 0);
    tick();
    run_conv("ignored start", 40'h0000000042, 32'h0000002A, 1'b0, 5);

    // Reset ten cycles into a conversion.
    bcd_input = 40'h1234567890;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst outs", {29'd0, binary_output, overflow, busy, done, error}, 64'd0);
    exp_last  = 32'h0;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done) done_seen++;
    end
    check_eq("midrst no done", 64'(done_seen), 64'd0);
    run_conv("100", 40'h0000000100, 32'h00000064, 1'b0, 0);

`ifdef BCD_DEC_CHECK_EN
    bcd_input = 40'h000000A000;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check_eq("bad done", {63'd0, done}, 64'd1);
    check_eq("bad err", {63'd0, error}, 64'd1);
    check_eq("bad busy", {63'd0, busy}, 64'd0);
    check_eq("bad bin", {32'd0, binary_output}, 64'd0);
    check_eq("bad ovf", {63'd0, overflow}, 64'd0);
    exp_last = 32'h0;
    run_conv("valid5", 40'h0000000005, 32'h00000005, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_decoder.md
# bcd_decoder

Sequential BCD-to-binary converter and the inverse of the benchmark's binary-to-BCD encoder. It takes a 10-digit packed BCD value and produces the 32-bit unsigned binary equivalent using reverse double-dabble: shift right, then subtract 3 from each digit that is ≥ 8. It sits in the BCDC benchmark path, so encoder output can be fed back through it for round-trip checking. It runs one iteration per clock, with a start/done handshake and an overflow flag.

## Interface
- `DIGITS`, default 10: number of BCD digits in the input.
- `OUT_WIDTH`, default 32: width of the binary result.
- `SHIFTS`, default 34: number of iterations. Must be ≥ ceil(DIGITS·log2 10); 34 covers 9 999 999 999.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE or DONE.
- `bcd_input`  in  4·DIGITS  packed digits; digit 0 (least significant) in [3:0], digit 9 in [39:36].
- `binary_output`  out  OUT_WIDTH  converted value, low OUT_WIDTH bits.
- `overflow`  out  1  result ≥ 2^OUT_WIDTH.
- `busy`  out  1  conversion in progress.
- `done`  out  1  result valid; a level, held until the next accepted start.
- `error`  out  1  an input digit was greater than 9 (see Configuration).

## Operation
- Internal work register is {bcd[4·DIGITS-1:0], bin[SHIFTS-1:0]}, plus an iteration counter of ceil(log2(SHIFTS+1)) bits.
- State machine: IDLE, SHIFT, DONE.
- **IDLE or DONE with `start`=1:**
  - load bcd ← `bcd_input`, bin ← 0, counter ← SHIFTS.
  - `done` ← 0, `busy` ← 1, go to SHIFT.
- **IDLE or DONE with `start`=0:** hold all outputs.
- **SHIFT, each cycle:**
  - shift {bcd, bin} right by 1, with 0 entering the MSB.
  - then, for every digit of the shifted bcd that is ≥ 8, subtract 3. All digits are corrected in parallel on the shifted value.
  - counter decrements.
  - on the cycle where counter goes 1 → 0:
    - `binary_output` ← final bin[OUT_WIDTH-1:0].
    - `overflow` ← |final bin[SHIFTS-1:OUT_WIDTH].
    - `done` ← 1, `busy` ← 0, go to DONE.
- **`start` during SHIFT:** ignored; the running conversion is not restarted.
- **Output stability:** `binary_output` and `overflow` change only on entry to DONE (or on reset). The previous result stays visible while busy.
- **Arithmetic:** all digit arithmetic is unsigned 4-bit. For valid input, no digit underflows after the −3 correction.

## Timing
- **Reset:** `binary_output`=0, `overflow`=0, `busy`=0, `done`=0, `error`=0, state IDLE, work register cleared.
- **Reset mid-conversion:** aborts the conversion next edge to the reset values. No `done` is produced for the aborted request.
- **Latency:** `start` accepted at edge k gives `busy`=1 after edge k and `done`=1 after edge k+SHIFTS (edge k+34 with defaults).
- **Back-to-back:** `start`=1 while in DONE is accepted at that edge. `done` drops after that same edge, so the next conversion begins with no idle cycle.
- **Mutual exclusion:** `busy` and `done` are never both 1.
- **`start` held high continuously:** a new conversion restarts on every edge spent in DONE, i.e. one conversion per SHIFTS+1 cycles.

## Configuration
- **`BCD_DEC_CHECK_EN` defined:**
  - When `start` is accepted, if any digit of `bcd_input` is > 9, go directly to DONE at the next edge.
  - In that case `error`=1, `binary_output`=0, `overflow`=0, and `done`=1 one cycle after acceptance (no SHIFT cycles).
  - Any accepted `start` with all digits valid clears `error` to 0 together with `done`.
- **`BCD_DEC_CHECK_EN` not defined:**
  - `error` is tied to 0 and there is no digit check.
  - Invalid digits are run through the algorithm unchanged. The result is deterministic but unspecified, and the bench does not check it.

## Test plan
- Reset, then `bcd_input`=0 with a start pulse → `done` after 34 cycles; `binary_output`=0x00000000, `overflow`=0.
- Digits 1234567890 → `binary_output`=0x499602D2, `overflow`=0; `busy` is high for exactly 34 cycles.
- Digits 4294967295 → 0xFFFFFFFF with `overflow`=0. Then digits 9999999999 back-to-back from DONE → 0x540BE3FF with `overflow`=1, with no idle cycle between the two conversions.
- `start` re-pulsed with 0000000007 during SHIFT of 0000000042 → the request is ignored; result 0x0000002A; `done` lands 34 cycles after the first start.
- `reset` asserted at cycle 10 of a conversion → all outputs 0 next edge and no `done`. A subsequent conversion of 0000000100 → 0x00000064.
- With `BCD_DEC_CHECK_EN`, digit 3 = 0xA → `done`=1 and `error`=1 one cycle after start, `binary_output`=0. A following valid input 0000000005 → `error`=0, result 0x00000005.
